regfile_scoreboard_fwd: RTL
===========================

REGFILE_SCOREBOARD_FWD -- requirements
Module: regfile_scoreboard_fwd

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; depth = 2**ADDR_W; PC is register index 2**ADDR_W-1.
REQ-003 Parameter NUM_RD, default 4: number of read ports.
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clock  in  1  sole clock; all state updates on posedge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 freeze  in  1  holds read outputs; blocks PC write and issue.
REQ-008 rd_en  in  NUM_RD  per-port read enable.
REQ-009 rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 rd_data  out  NUM_RD*DATA_W  packed registered read data; port i at bits [i*DATA_W +: DATA_W].
REQ-011 wb0_en, wb0_addr, wb0_data  in  1/ADDR_W/DATA_W  result writeback port.
REQ-012 wb1_en, wb1_addr, wb1_data  in  1/ADDR_W/DATA_W  base-register update port.
REQ-013 pc_wr_en, pc_next  in  1/DATA_W  PC update.
REQ-014 pc_content  out  DATA_W  current PC register, combinational from array.
REQ-015 issue_en, issue_addr  in  1/ADDR_W  marks destination register pending.
REQ-016 stall  out  1  combinational read-after-write hazard indication.

Function
REQ-017 Array write at posedge; priority per address: wb0 > wb1 > PC write (pc_wr_en & ~freeze).
REQ-018 wb0 and wb1 to the same address in one cycle: wb0_data SHALL be stored and wb1 dropped.
REQ-019 Read latency 1 cycle: rd_data[i] SHALL load at posedge when rd_en[i] & ~freeze & ~stall; otherwise it holds.
REQ-020 Same-cycle bypass: a read whose address matches an active write SHALL return that write data, using the priority of REQ-017.
REQ-021 Each register has a pending bit; it is set at posedge by issue_en & ~freeze & ~stall at issue_addr, and cleared by wb0_en or wb1_en at that address.
REQ-022 Simultaneous set and clear of the same pending bit: set SHALL win.
REQ-023 stall = OR over i of (rd_en[i] & pending[rd_addr[i]] & no active write to rd_addr[i] this cycle).
REQ-024 While stall=1: rd_data holds, the issue is ignored, and writebacks proceed.
REQ-025 freeze does not block wb0/wb1 writes or pending-bit clears.
REQ-026 Addresses wrap naturally within ADDR_W bits; there is no out-of-range case.

Reset
REQ-027 On reset_n low, asynchronously: all registers, including PC, SHALL be 0; all pending bits 0; rd_data 0; stall therefore 0.
REQ-028 Reset mid-operation SHALL discard all in-flight pending state; the first posedge after release behaves as a fresh start.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN: when defined, REQ-020 bypass and the write term of REQ-023 apply.
REQ-030 Without REGFILE_BYPASS_EN: reads return pre-write array contents, and stall SHALL also assert for a read matching any active write (rd_en[i] & (pending | write-hit)).

Verification
REQ-031 Reset then read all 16 addresses on port 0 -> each rd_data returns 0 one cycle after the read.
REQ-032 wb0 r3=0xAAAA and wb1 r3=0x5555 in the same cycle -> r3 reads 0xAAAA next cycle.
REQ-033 Issue r5; next cycle read r5 -> stall=1 and rd_data held; then wb0 r5=0x1234 with read r5 in the same cycle -> stall=0 and rd_data=0x1234 (bypass build).
REQ-034 freeze=1 with pc_wr_en, pc_next=0x40 and wb0 r2=7 -> PC unchanged, r2=7, rd_data held.
REQ-035 Issue r7 and wb0 r7 in the same cycle -> pending[r7] stays 1, and a read of r7 next cycle asserts stall.
REQ-036 Build without REGFILE_BYPASS_EN: wb0 r4=9 with a same-cycle read of r4 -> stall=1; the next cycle read returns 9.

Source files
------------

// File: rtl/regfile_scoreboard_fwd_if.sv
// Bundle of the register-file scoreboard's read, writeback, PC and issue signals.
// master drives the requests; slave is the register file itself.
interface regfile_scoreboard_fwd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 4
);
  logic                       freeze;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       wb0_en;
  logic [ADDR_W-1:0]          wb0_addr;
  logic [DATA_W-1:0]          wb0_data;
  logic                       wb1_en;
  logic [ADDR_W-1:0]          wb1_addr;
  logic [DATA_W-1:0]          wb1_data;
  logic                       pc_wr_en;
  logic [DATA_W-1:0]          pc_next;
  logic [DATA_W-1:0]          pc_content;
  logic                       issue_en;
  logic [ADDR_W-1:0]          issue_addr;
  logic                       stall;

  modport master (
    output freeze, rd_en, rd_addr, wb0_en, wb0_addr, wb0_data,
           wb1_en, wb1_addr, wb1_data, pc_wr_en, pc_next, issue_en, issue_addr,
    input  rd_data, pc_content, stall
  );

  modport slave (
    input  freeze, rd_en, rd_addr, wb0_en, wb0_addr, wb0_data,
           wb1_en, wb1_addr, wb1_data, pc_wr_en, pc_next, issue_en, issue_addr,
    output rd_data, pc_content, stall
  );
endinterface

// File: rtl/regfile_scoreboard_fwd.sv
// Multi-port register file with PC register, pending-bit scoreboard and RAW stall.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to reads instead of stalling.
module regfile_scoreboard_fwd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  regfile_scoreboard_fwd_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PC_IDX = DEPTH - 1;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]         pend_q;
  logic [DEPTH-1:0]         pend_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD*DATA_W-1:0] rd_data_d;

  logic                     pc_we_s;
  logic                     issue_ok_s;
  logic                     stall_s;
  logic [ADDR_W-1:0]        rd_a_s   [NUM_RD];
  logic [DATA_W-1:0]        rd_val_s [NUM_RD];
  logic [NUM_RD-1:0]        hit_s;

  assign pc_we_s    = bus.pc_wr_en & ~bus.freeze;
  assign issue_ok_s = bus.issue_en & ~bus.freeze & ~stall_s;

  // Per-port write-hit detection, read value selection and stall reduction.
  always_comb begin
    stall_s = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a_s[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (bus.wb0_en && (bus.wb0_addr == rd_a_s[i])) begin
        hit_s[i] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        rd_val_s[i] = bus.wb0_data;
`else
        rd_val_s[i] = mem_q[rd_a_s[i]];
`endif
      end else if (bus.wb1_en && (bus.wb1_addr == rd_a_s[i])) begin
        hit_s[i] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        rd_val_s[i] = bus.wb1_data;
`else
        rd_val_s[i] = mem_q[rd_a_s[i]];
`endif
      end else if (pc_we_s && (rd_a_s[i] == ADDR_W'(PC_IDX))) begin
        hit_s[i] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        rd_val_s[i] = bus.pc_next;
`else
        rd_val_s[i] = mem_q[rd_a_s[i]];
`endif
      end else begin
        hit_s[i]    = 1'b0;
        rd_val_s[i] = mem_q[rd_a_s[i]];
      end
`ifdef REGFILE_BYPASS_EN
      stall_s = stall_s | (bus.rd_en[i] & pend_q[rd_a_s[i]] & ~hit_s[i]);
`else
      stall_s = stall_s | (bus.rd_en[i] & (pend_q[rd_a_s[i]] | hit_s[i]));
`endif
    end
  end

  // Read data loads only on an enabled, unfrozen, unstalled cycle.
  always_comb begin
    rd_data_d = rd_data_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_en[i] && !bus.freeze && !stall_s) begin
        rd_data_d[i*DATA_W +: DATA_W] = rd_val_s[i];
      end else begin
        rd_data_d[i*DATA_W +: DATA_W] = rd_data_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // Array next state: wb0 beats wb1 beats the PC update on the same entry.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      if (bus.wb0_en && (bus.wb0_addr == ADDR_W'(j))) begin
        mem_d[j] = bus.wb0_data;
      end else if (bus.wb1_en && (bus.wb1_addr == ADDR_W'(j))) begin
        mem_d[j] = bus.wb1_data;
      end else if (pc_we_s && (j == PC_IDX)) begin
        mem_d[j] = bus.pc_next;
      end else begin
        mem_d[j] = mem_q[j];
      end
    end
  end

  // Pending bits: a new issue outranks a writeback clearing the same entry.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      if (issue_ok_s && (bus.issue_addr == ADDR_W'(j))) begin
        pend_d[j] = 1'b1;
      end else if ((bus.wb0_en && (bus.wb0_addr == ADDR_W'(j))) ||
                   (bus.wb1_en && (bus.wb1_addr == ADDR_W'(j)))) begin
        pend_d[j] = 1'b0;
      end else begin
        pend_d[j] = pend_q[j];
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
      pend_q    <= '0;
      rd_data_q <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= mem_d[j];
      end
      pend_q    <= pend_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.pc_content = mem_q[PC_IDX];
  assign bus.stall      = stall_s;
endmodule
